// File: rtl/bcd4digit_to_binary_pkg.sv
// ---------------------------------------------------------------------------
// bcd4digit_to_binary_pkg
// Constants shared by the BCD <-> binary converters.
//   - State encodings for the start/done conversion FSMs.
//   - BCD digit width and largest legal digit value.
//   - digit_invalid(): flags a nibble that is not a decimal digit.
// ---------------------------------------------------------------------------
package bcd4digit_to_binary_pkg;

    localparam int STATE_SIZE = 2;
    localparam logic [STATE_SIZE-1:0] ST_IDLE  = 2'd0;
    localparam logic [STATE_SIZE-1:0] ST_ACCUM = 2'd1;
    localparam logic [STATE_SIZE-1:0] ST_DONE  = 2'd2;

    localparam int BCD_DIGIT_W = 4;
    localparam logic [BCD_DIGIT_W-1:0] BCD_MAX_DIGIT = 4'd9;

    typedef enum logic [STATE_SIZE-1:0] {
        S_IDLE  = ST_IDLE,
        S_ACCUM = ST_ACCUM,
        S_DONE  = ST_DONE
    } state_t;

    function automatic logic digit_invalid(input logic [BCD_DIGIT_W-1:0] d);
        return d > BCD_MAX_DIGIT;
    endfunction

endpackage

// File: rtl/bcd4digit_to_binary_if.sv
// ---------------------------------------------------------------------------
// bcd4digit_to_binary_if
// Start/done handshake bundle for the BCD-to-binary converter.
//   start : conversion request (master -> slave)
//   bcd   : packed BCD operand, most significant digit in the top nibble
//   value : binary result
//   done  : one-cycle result-valid pulse
//   busy  : conversion in progress (through the done cycle)
//   error : invalid digit seen (only when the digit check is built in)
// Modports: master = requester, slave = converter.
// ---------------------------------------------------------------------------
interface bcd4digit_to_binary_if
    import bcd4digit_to_binary_pkg::*;
#(
    parameter int DIGITS    = 4,
    parameter int OUT_WIDTH = 14
);
    logic                          start;
    logic [DIGITS*BCD_DIGIT_W-1:0] bcd;
    logic [OUT_WIDTH-1:0]          value;
    logic                          done;
    logic                          busy;
    logic                          error;

    modport master (
        output start, bcd,
        input  value, done, busy, error
    );

    modport slave (
        input  start, bcd,
        output value, done, busy, error
    );
endinterface

// File: rtl/bcd4digit_to_binary_control.sv
// ---------------------------------------------------------------------------
// bcd4digit_to_binary_control
// Conversion sequencer: IDLE -> ACCUM (one cycle per digit) -> DONE -> IDLE.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   start       : request, only honoured in IDLE
//   bad_digit   : operand holds a non-decimal nibble (tied low when unchecked)
//   last_digit  : the current ACCUM cycle consumes the final digit
//   load        : capture operand / clear datapath (start accepted)
//   accum       : perform one multiply-by-10-and-add step
//   finish      : result valid (drives done)
//   busy        : any state other than IDLE
// ---------------------------------------------------------------------------
module bcd4digit_to_binary_control
    import bcd4digit_to_binary_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic bad_digit,
    input  logic last_digit,
    output logic load,
    output logic accum,
    output logic finish,
    output logic busy
);
    state_t state_reg, state_next;

    always_ff @(posedge clk) begin
        if (rst) state_reg <= S_IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        load       = 1'b0;
        accum      = 1'b0;
        finish     = 1'b0;
        busy       = (state_reg != S_IDLE);
        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    load = 1'b1;
                    // An invalid operand skips accumulation entirely.
                    state_next = bad_digit ? S_DONE : S_ACCUM;
                end
            end
            S_ACCUM: begin
                accum = 1'b1;
                if (last_digit) state_next = S_DONE;
            end
            S_DONE: begin
                finish     = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end
endmodule

// File: rtl/bcd4digit_to_binary.sv
// ---------------------------------------------------------------------------
// bcd4digit_to_binary
// Converts a packed BCD number into unsigned binary by Horner's rule,
// acc = acc*10 + digit, most significant digit first, one digit per clock.
// Latency from accepted start to done is DIGITS+1 cycles.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of bcd4digit_to_binary_if (start/bcd in,
//              value/done/busy/error out)
// Build option:
//   BCD4DIGIT_CHECK_EN - reject operands containing a nibble > 9; such a
//   start returns done after one cycle with error=1 and value=0. Without
//   it, error is tied low and all nibbles are accumulated arithmetically.
// ---------------------------------------------------------------------------
module bcd4digit_to_binary
    import bcd4digit_to_binary_pkg::*;
#(
    parameter int DIGITS    = 4,
    parameter int OUT_WIDTH = 14
)(
    input  logic                    clk,
    input  logic                    rst,
    bcd4digit_to_binary_if.slave    bus
);
    localparam int BCD_W = DIGITS * BCD_DIGIT_W;
    localparam int CNT_W = $clog2(DIGITS + 1);

    logic [BCD_W-1:0]       shreg_reg;
    logic [OUT_WIDTH-1:0]   acc_reg;
    logic [OUT_WIDTH-1:0]   acc_next;
    logic [CNT_W-1:0]       cnt_reg;
    logic [BCD_DIGIT_W-1:0] top_nibble;

    logic load, accum, finish, busy;
    logic bad_digit, last_digit;

    assign top_nibble = shreg_reg[BCD_W-1 -: BCD_DIGIT_W];
    assign last_digit = (cnt_reg == CNT_W'(DIGITS - 1));

    // x10 as x8 + x2; wraps modulo 2^OUT_WIDTH for non-decimal nibbles.
    assign acc_next = (acc_reg << 3) + (acc_reg << 1) + OUT_WIDTH'(top_nibble);

    bcd4digit_to_binary_control u_control (
        .clk        (clk),
        .rst        (rst),
        .start      (bus.start),
        .bad_digit  (bad_digit),
        .last_digit (last_digit),
        .load       (load),
        .accum      (accum),
        .finish     (finish),
        .busy       (busy)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg_reg <= '0;
            acc_reg   <= '0;
            cnt_reg   <= '0;
        end else if (load) begin
            shreg_reg <= bus.bcd;
            acc_reg   <= '0;
            cnt_reg   <= '0;
        end else if (accum) begin
            acc_reg   <= acc_next;
            shreg_reg <= {shreg_reg[BCD_W-BCD_DIGIT_W-1:0], {BCD_DIGIT_W{1'b0}}};
            cnt_reg   <= cnt_reg + 1'b1;
        end
    end

`ifdef BCD4DIGIT_CHECK_EN
    logic [DIGITS-1:0] nibble_bad;
    logic              error_reg;

    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit_check
        assign nibble_bad[gi] = digit_invalid(bus.bcd[gi*BCD_DIGIT_W +: BCD_DIGIT_W]);
    end
    assign bad_digit = |nibble_bad;

    // Captured on the accepted start and held with value until the next one.
    always_ff @(posedge clk) begin
        if (rst)       error_reg <= 1'b0;
        else if (load) error_reg <= bad_digit;
    end
    assign bus.error = error_reg;
`else
    assign bad_digit = 1'b0;
    assign bus.error = 1'b0;
`endif

    // The accumulator is cleared on start and untouched after DONE, so it
    // already provides the hold-until-next-start behaviour of value.
    assign bus.value = acc_reg;
    assign bus.done  = finish;
    assign bus.busy  = busy;
endmodule

// File: tb/tb_bcd4digit_to_binary.sv
module tb_bcd4digit_to_binary;
    import bcd4digit_to_binary_pkg::*;

    typedef struct packed {
        logic [13:0] value;
        logic        error;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    bcd4digit_to_binary_if #(.DIGITS(4), .OUT_WIDTH(14)) bus ();

    bcd4digit_to_binary #(.DIGITS(4), .OUT_WIDTH(14)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    // Reference: positional decimal weights, not the iterative datapath.
    function automatic exp_t model(input logic [15:0] b);
        exp_t        m;
        int unsigned sum;
        sum = 32'(b[15:12]) * 1000 + 32'(b[11:8]) * 100 + 32'(b[7:4]) * 10 + 32'(b[3:0]);
        m.value = 14'(sum % 16384);
        m.error = 1'b0;
`ifdef BCD4DIGIT_CHECK_EN
        if (b[15:12] > 9 || b[11:8] > 9 || b[7:4] > 9 || b[3:0] > 9) begin
            m.value = '0;
            m.error = 1'b1;
        end
`endif
        return m;
    endfunction

    // Drive a one-cycle start; returns just after the accepting edge E0.
    task automatic kick(input logic [15:0] b);
        @(negedge clk);
        bus.start = 1'b1;
        bus.bcd   = b;
        sb.push_back(model(b));
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    // Observe outputs (negedge samples) until done; lat counts cycles after E0.
    task automatic collect(output int lat, output int busy_cyc, output logic [13:0] v,
                           output logic e, output bit timeout);
        lat = 0; busy_cyc = 0; v = '0; e = 1'b0; timeout = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (bus.busy) busy_cyc++;
            if (bus.done) begin
                lat = i; v = bus.value; e = bus.error; timeout = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        vectors++; if (bus.value !== 14'd0) begin miscompares++; $display("FAIL reset_value: got %0d expected 0", bus.value); end
        vectors++; if (bus.done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b expected 0", bus.done); end
        vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        vectors++; if (bus.error !== 1'b0) begin miscompares++; $display("FAIL reset_error: got %b expected 0", bus.error); end
        rst = 1'b0;
    endtask

    task automatic run_table(input string name, input logic [15:0] tbl[]);
        int lat, bcyc, exp_lat; logic [13:0] v; logic e; bit to; exp_t ex;
        foreach (tbl[k]) begin
            kick(tbl[k]);
            collect(lat, bcyc, v, e, to);
            ex = sb.pop_front();
            exp_lat = ex.error ? 1 : 5;
            $display("%s bcd=%h value=%0d error=%b latency=%0d", name, tbl[k], v, e, lat);
            vectors++;
            if (to) begin miscompares++; $display("FAIL %s_timeout bcd=%h: no done within 12 cycles", name, tbl[k]); continue; end
            vectors++; if (lat !== exp_lat) begin miscompares++; $display("FAIL %s_latency bcd=%h: got %0d expected %0d", name, tbl[k], lat, exp_lat); end
            vectors++; if (bcyc !== exp_lat) begin miscompares++; $display("FAIL %s_busy bcd=%h: got %0d cycles expected %0d", name, tbl[k], bcyc, exp_lat); end
            vectors++; if (v !== ex.value) begin miscompares++; $display("FAIL %s_value bcd=%h: got %0d expected %0d", name, tbl[k], v, ex.value); end
            vectors++; if (e !== ex.error) begin miscompares++; $display("FAIL %s_error bcd=%h: got %b expected %b", name, tbl[k], e, ex.error); end
        end
    endtask

    task automatic test_values();
        logic [15:0] tbl[] = '{16'h1234, 16'h0000, 16'h9999};
        run_table("values", tbl);
        // Result must hold after done while no new start arrives.
        repeat (4) @(negedge clk);
        vectors++; if (bus.value !== 14'd9999) begin miscompares++; $display("FAIL hold_value: got %0d expected 9999", bus.value); end
        vectors++; if (bus.done !== 1'b0) begin miscompares++; $display("FAIL hold_done: got %b expected 0", bus.done); end
    endtask

    task automatic test_invalid();
        logic [15:0] tbl[] = '{16'h12A4, 16'hFFFF};
        run_table("invalid", tbl);
    endtask

    task automatic test_back_to_back();
        int ndone = 0, last_i = 0, extra = 0; exp_t ex;
        @(negedge clk);
        bus.start = 1'b1;
        bus.bcd   = 16'h0042;
        repeat (3) sb.push_back(model(16'h0042));
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (bus.done) begin
                ex = sb.pop_front();
                $display("b2b done at cycle %0d value=%0d", i, bus.value);
                vectors++; if (bus.value !== ex.value) begin miscompares++; $display("FAIL b2b_value: got %0d expected %0d", bus.value, ex.value); end
                if (ndone > 0) begin
                    vectors++; if (i - last_i !== 6) begin miscompares++; $display("FAIL b2b_spacing: got %0d cycles expected 6", i - last_i); end
                end
                last_i = i;
                ndone++;
                if (ndone == 3) begin bus.start = 1'b0; break; end
            end
        end
        bus.start = 1'b0;
        vectors++; if (ndone !== 3) begin miscompares++; $display("FAIL b2b_count: got %0d conversions expected 3", ndone); end
        sb.delete();
        repeat (8) begin @(negedge clk); if (bus.done) extra++; end
        vectors++; if (extra !== 0) begin miscompares++; $display("FAIL b2b_queued: got %0d extra done expected 0", extra); end
    endtask

    task automatic test_ignore_start();
        int got = 0; exp_t ex;
        kick(16'h1111);
        ex = sb.pop_front();
        for (int i = 1; i <= 14; i++) begin
            @(negedge clk);
            if (bus.done) begin
                if (got == 0) begin
                    $display("ignore done at cycle %0d value=%0d", i, bus.value);
                    vectors++; if (i !== 5) begin miscompares++; $display("FAIL ignore_latency: got %0d expected 5", i); end
                    vectors++; if (bus.value !== ex.value) begin miscompares++; $display("FAIL ignore_value: got %0d expected %0d", bus.value, ex.value); end
                end
                got++;
            end
            // Requests during ACCUM and during the DONE cycle must be dropped.
            bus.start = (i == 2 || i == 5);
            bus.bcd   = 16'h2222;
        end
        bus.start = 1'b0;
        vectors++; if (got !== 1) begin miscompares++; $display("FAIL ignore_count: got %0d done pulses expected 1", got); end
    endtask

    task automatic test_reset_abort();
        int extra = 0, lat, bcyc; logic [13:0] v; logic e; bit to; exp_t ex;
        @(negedge clk);
        bus.start = 1'b1;
        bus.bcd   = 16'h5678;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;               // sampled at E3
        @(negedge clk);
        $display("abort after E3 value=%0d done=%b busy=%b", bus.value, bus.done, bus.busy);
        vectors++; if (bus.value !== 14'd0) begin miscompares++; $display("FAIL abort_value: got %0d expected 0", bus.value); end
        vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL abort_busy: got %b expected 0", bus.busy); end
        vectors++; if (bus.done !== 1'b0) begin miscompares++; $display("FAIL abort_done: got %b expected 0", bus.done); end
        vectors++; if (bus.error !== 1'b0) begin miscompares++; $display("FAIL abort_error: got %b expected 0", bus.error); end
        rst = 1'b0;
        repeat (8) begin @(negedge clk); if (bus.done) extra++; end
        vectors++; if (extra !== 0) begin miscompares++; $display("FAIL abort_stray_done: got %0d expected 0", extra); end
        kick(16'h0007);
        collect(lat, bcyc, v, e, to);
        ex = sb.pop_front();
        $display("post-abort bcd=0007 value=%0d latency=%0d", v, lat);
        vectors++; if (to || v !== ex.value) begin miscompares++; $display("FAIL abort_next_value: got %0d expected %0d", v, ex.value); end
        vectors++; if (lat !== 5) begin miscompares++; $display("FAIL abort_next_latency: got %0d expected 5", lat); end
    endtask

    task automatic test_reset_start_same_edge();
        int got = 0;
        @(negedge clk);
        rst = 1'b1;
        bus.start = 1'b1;
        bus.bcd   = 16'h0123;
        @(negedge clk);
        rst = 1'b0;
        bus.start = 1'b0;
        vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL rst_start_busy: got %b expected 0", bus.busy); end
        repeat (8) begin @(negedge clk); if (bus.done) got++; end
        vectors++; if (got !== 0) begin miscompares++; $display("FAIL rst_start_done: got %0d expected 0", got); end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.bcd   = '0;
        rst       = 1'b1;
        test_reset();
        test_values();
        test_invalid();
        test_back_to_back();
        test_ignore_start();
        test_reset_abort();
        test_reset_start_same_edge();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
